// File: rtl/pwm_cmp_update_ctrl.sv
// rtl/pwm_cmp_update_ctrl.sv - shadow/active compare register update controller for PWM channels
module pwm_cmp_update_ctrl #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 12,
  parameter int CH_W   = 4
) (
  input  logic                    clk_psc_i,
  input  logic                    rst_i,
  input  logic                    wr_req_i,
  input  logic [CH_W-1:0]         wr_ch_i,
  input  logic [CNT_W-1:0]        wr_start_i,
  input  logic [CNT_W-1:0]        wr_end_i,
  input  logic                    wr_mode_i,
  output logic                    wr_ack_o,
  output logic                    wr_err_o,
  input  logic                    cnt_wrap_i,
  input  logic                    upd_en_i,
  input  logic                    force_upd_i,
  output logic [NUM_CH*CNT_W-1:0] cmp_start_o,
  output logic [NUM_CH*CNT_W-1:0] cmp_end_o,
  output logic [NUM_CH-1:0]       mode_o,
  output logic [NUM_CH-1:0]       pend_o,
  output logic                    upd_done_o,
  output logic [7:0]              upd_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } wr_state_e;

  wr_state_e state_q, state_d;

  logic [CNT_W-1:0] sh_start  [NUM_CH];
  logic [CNT_W-1:0] sh_end    [NUM_CH];
  logic             sh_mode   [NUM_CH];
  logic [CNT_W-1:0] act_start [NUM_CH];
  logic [CNT_W-1:0] act_end   [NUM_CH];
  logic             act_mode  [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic             err_q;
  logic             done_q;
  logic [7:0]       cnt_q;

  logic wr_take;
  logic wr_ok;
  logic commit;

  // Write is taken on the IDLE edge that first sees the request; validity is judged on that edge's data.
  assign wr_take = (state_q == ST_IDLE) && wr_req_i;
  assign wr_ok   = (32'(wr_ch_i) < NUM_CH) && (wr_start_i <= wr_end_i);
  assign commit  = (cnt_wrap_i && upd_en_i) || force_upd_i;

  // Handshake state register.
  always_ff @(posedge clk_psc_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Handshake next-state: one ack per request, request must drop before the next one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (wr_req_i) state_d = ST_ACK;
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: if (!wr_req_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow load, commit to active, pending flags; a write on a commit edge lands after the commit.
  always_ff @(posedge clk_psc_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_start[i]  <= '0;
        sh_end[i]    <= '0;
        sh_mode[i]   <= 1'b0;
        act_start[i] <= '0;
        act_end[i]   <= '0;
        act_mode[i]  <= 1'b0;
      end
      pend_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (commit && pend_q[i]) begin
          act_start[i] <= sh_start[i];
          act_end[i]   <= sh_end[i];
          act_mode[i]  <= sh_mode[i];
          pend_q[i]    <= 1'b0;
        end
        if (wr_take && wr_ok && (wr_ch_i == CH_W'(i))) begin
          sh_start[i] <= wr_start_i;
          sh_end[i]   <= wr_end_i;
          sh_mode[i]  <= wr_mode_i;
          pend_q[i]   <= 1'b1;
        end
      end
      if (wr_take) err_q <= !wr_ok;
      done_q <= commit && (|pend_q);
      if (commit && (|pend_q)) cnt_q <= cnt_q + 8'd1;
    end
  end

  // Pack active registers onto the flat comparator buses.
  always_comb begin
    cmp_start_o = '0;
    cmp_end_o   = '0;
    mode_o      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_start_o[i*CNT_W +: CNT_W] = act_start[i];
      cmp_end_o[i*CNT_W +: CNT_W]   = act_end[i];
      mode_o[i]                     = act_mode[i];
    end
  end

  assign wr_ack_o   = (state_q == ST_ACK);
  assign wr_err_o   = (state_q == ST_ACK) && err_q;
  assign pend_o     = pend_q;
  assign upd_done_o = done_q;
  assign upd_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pwm_cmp_update_ctrl.sv
// tb/tb_pwm_cmp_update_ctrl.sv - self-checking bench for pwm_cmp_update_ctrl
module tb_pwm_cmp_update_ctrl;
  localparam int NUM_CH = 16;
  localparam int CNT_W  = 12;
  localparam int CH_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_req = 1'b0;
  logic [CH_W-1:0] wr_ch = '0;
  logic [CNT_W-1:0] wr_start = '0, wr_end = '0;
  logic wr_mode = 1'b0;
  logic wr_ack, wr_err;
  logic cnt_wrap = 1'b0, upd_en = 1'b1, force_upd = 1'b0;
  logic [NUM_CH*CNT_W-1:0] cmp_start, cmp_end;
  logic [NUM_CH-1:0] mode, pend;
  logic upd_done;
  logic [7:0] upd_cnt;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pwm_cmp_update_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk_psc_i(clk), .rst_i(rst),
    .wr_req_i(wr_req), .wr_ch_i(wr_ch), .wr_start_i(wr_start), .wr_end_i(wr_end),
    .wr_mode_i(wr_mode), .wr_ack_o(wr_ack), .wr_err_o(wr_err),
    .cnt_wrap_i(cnt_wrap), .upd_en_i(upd_en), .force_upd_i(force_upd),
    .cmp_start_o(cmp_start), .cmp_end_o(cmp_end), .mode_o(mode), .pend_o(pend),
    .upd_done_o(upd_done), .upd_cnt_o(upd_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what each channel's shadow/active values and the handshake outputs must be.
  int m_sh_s [NUM_CH], m_sh_e [NUM_CH], m_sh_m [NUM_CH];
  int m_ac_s [NUM_CH], m_ac_e [NUM_CH], m_ac_m [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_ack, m_err, m_done, m_armed, m_skip;
  int m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_sh_s[i] = 0; m_sh_e[i] = 0; m_sh_m[i] = 0;
        m_ac_s[i] = 0; m_ac_e[i] = 0; m_ac_m[i] = 0; m_pend[i] = 0;
      end
      m_ack = 0; m_err = 0; m_done = 0; m_cnt = 0; m_armed = 1; m_skip = 0;
    end else begin
      bit trig, any;
      trig = (cnt_wrap && upd_en) || force_upd;
      any = 0;
      for (int i = 0; i < NUM_CH; i++) any |= m_pend[i];
      m_done = trig && any;
      if (m_done) m_cnt = (m_cnt + 1) % 256;
      if (trig)
        for (int i = 0; i < NUM_CH; i++)
          if (m_pend[i]) begin
            m_ac_s[i] = m_sh_s[i]; m_ac_e[i] = m_sh_e[i]; m_ac_m[i] = m_sh_m[i];
            m_pend[i] = 0;
          end
      m_ack = 0; m_err = 0;
      if (m_armed && wr_req) begin
        m_ack = 1;
        m_err = !(int'(wr_start) <= int'(wr_end) && int'(wr_ch) < NUM_CH);
        if (!m_err) begin
          m_sh_s[wr_ch] = wr_start; m_sh_e[wr_ch] = wr_end; m_sh_m[wr_ch] = wr_mode;
          m_pend[wr_ch] = 1;
        end
        m_armed = 0; m_skip = 1;
      end else if (!m_armed) begin
        if (m_skip) m_skip = 0;
        else if (!wr_req) m_armed = 1;
      end
    end
  end

  // Compare process: every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", 32'(wr_ack), 32'(m_ack));
      chk("err", 32'(wr_err), 32'(m_ack && m_err));
      chk("done", 32'(upd_done), 32'(m_done));
      chk("cnt", 32'(upd_cnt), 32'(m_cnt));
      for (int i = 0; i < NUM_CH; i++) begin
        chk($sformatf("start%0d", i), 32'(cmp_start[i*CNT_W +: CNT_W]), 32'(m_ac_s[i]));
        chk($sformatf("end%0d", i), 32'(cmp_end[i*CNT_W +: CNT_W]), 32'(m_ac_e[i]));
        chk($sformatf("mode%0d", i), 32'(mode[i]), 32'(m_ac_m[i]));
        chk($sformatf("pend%0d", i), 32'(pend[i]), 32'(m_pend[i]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Raise a request, wait (bounded) for its ack, then release and let the handshake return to idle.
  task automatic write_ch(input int ch, input int s, input int e, input bit m, input bit with_wrap);
    bit seen;
    wr_req = 1; wr_ch = CH_W'(ch); wr_start = CNT_W'(s); wr_end = CNT_W'(e); wr_mode = m;
    cnt_wrap = with_wrap;
    seen = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      step(1);
      cnt_wrap = 0;
      if (wr_ack) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_timeout ch%0d: got no ack expected ack", ch);
    end
  endtask

  task automatic release_req();
    wr_req = 0;
    step(3);
  endtask

  task automatic pulse_wrap(input bit frc);
    cnt_wrap = !frc; force_upd = frc;
    step(1);
    cnt_wrap = 0; force_upd = 0;
  endtask

  initial begin
    int acks;
    step(2);
    chk_on = 1;
    rst = 0;
    // reset state and idle
    chk("rst_start", 32'(cmp_start[31:0]), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_cnt", 32'(upd_cnt), 32'h0);
    acks = 0;
    for (int k = 0; k < 10; k++) begin step(1); acks += int'(wr_ack); end
    chk("idle_acks", 32'(acks), 32'd0);

    // ch3 write, commit on wrap
    write_ch(3, 'h100, 'h300, 1'b1, 1'b0);
    chk("ch3_ack", 32'(wr_ack), 32'd1);
    chk("ch3_err", 32'(wr_err), 32'd0);
    chk("ch3_pend", 32'(pend), 32'h0008);
    release_req();
    chk("ch3_pre", 32'(cmp_start[3*CNT_W +: CNT_W]), 32'h0);
    pulse_wrap(1'b0);
    chk("ch3_start", 32'(cmp_start[3*CNT_W +: CNT_W]), 32'h100);
    chk("ch3_end", 32'(cmp_end[3*CNT_W +: CNT_W]), 32'h300);
    chk("ch3_mode", 32'(mode[3]), 32'd1);
    chk("ch3_pend0", 32'(pend), 32'h0);
    chk("ch3_done", 32'(upd_done), 32'd1);
    chk("ch3_cnt", 32'(upd_cnt), 32'd1);

    // rejected write: start > end
    write_ch(5, 'h200, 'h1FF, 1'b0, 1'b0);
    chk("ch5_err", 32'(wr_err), 32'd1);
    chk("ch5_pend", 32'(pend), 32'h0);
    release_req();
    pulse_wrap(1'b0);
    chk("ch5_done", 32'(upd_done), 32'd0);
    chk("ch5_cnt", 32'(upd_cnt), 32'd1);

    // start == end accepted; write coincident with a wrap stays pending
    write_ch(7, 'h010, 'h020, 1'b0, 1'b1);
    chk("ch7_act", 32'(cmp_start[7*CNT_W +: CNT_W]), 32'h0);
    chk("ch7_pend", 32'(pend), 32'h0080);
    release_req();
    pulse_wrap(1'b0);
    chk("ch7_start", 32'(cmp_start[7*CNT_W +: CNT_W]), 32'h010);
    chk("ch7_end", 32'(cmp_end[7*CNT_W +: CNT_W]), 32'h020);
    chk("ch7_cnt", 32'(upd_cnt), 32'd2);
    write_ch(9, 'h055, 'h055, 1'b1, 1'b0);
    chk("ch9_eq_err", 32'(wr_err), 32'd0);
    release_req();
    pulse_wrap(1'b0);
    chk("ch9_start", 32'(cmp_start[9*CNT_W +: CNT_W]), 32'h055);
    chk("ch9_cnt", 32'(upd_cnt), 32'd3);

    // updates held off, then forced; last write wins on ch0
    upd_en = 0;
    write_ch(0, 'h007, 'h008, 1'b1, 1'b0);
    release_req();
    write_ch(0, 'h001, 'h002, 1'b0, 1'b0);
    release_req();
    write_ch(15, 'hABC, 'hFFF, 1'b1, 1'b0);
    release_req();
    repeat (3) begin pulse_wrap(1'b0); step(1); end
    chk("hold_pend", 32'(pend), 32'h8001);
    chk("hold_cnt", 32'(upd_cnt), 32'd3);
    pulse_wrap(1'b1);
    chk("frc_ch0_end", 32'(cmp_end[0 +: CNT_W]), 32'h002);
    chk("frc_ch0_mode", 32'(mode[0]), 32'd0);
    chk("frc_ch15_start", 32'(cmp_start[15*CNT_W +: CNT_W]), 32'hABC);
    chk("frc_ch15_end", 32'(cmp_end[15*CNT_W +: CNT_W]), 32'hFFF);
    chk("frc_pend", 32'(pend), 32'h0);
    chk("frc_cnt", 32'(upd_cnt), 32'd4);

    // wrap and force on the same edge count once
    upd_en = 1;
    write_ch(1, 'h0AA, 'h0BB, 1'b0, 1'b0);
    release_req();
    cnt_wrap = 1; force_upd = 1;
    step(1);
    cnt_wrap = 0; force_upd = 0;
    chk("both_done", 32'(upd_done), 32'd1);
    chk("both_cnt", 32'(upd_cnt), 32'd5);
    step(1);
    chk("both_done_off", 32'(upd_done), 32'd0);

    // long request gives exactly one ack
    wr_req = 1; wr_ch = 4'd2; wr_start = 12'h003; wr_end = 12'h004; wr_mode = 0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin step(1); acks += int'(wr_ack); end
    wr_req = 0;
    for (int k = 0; k < 3; k++) begin step(1); acks += int'(wr_ack); end
    chk("long_acks", 32'(acks), 32'd1);

    // reset while in HOLD
    write_ch(4, 'h010, 'h011, 1'b1, 1'b0);
    step(2);
    rst = 1;
    step(1);
    chk("rstH_ack", 32'(wr_ack), 32'd0);
    chk("rstH_start", 32'(|cmp_start), 32'd0);
    chk("rstH_end", 32'(|cmp_end), 32'd0);
    chk("rstH_mode", 32'(mode), 32'd0);
    chk("rstH_pend", 32'(pend), 32'd0);
    chk("rstH_cnt", 32'(upd_cnt), 32'd0);
    rst = 0; wr_req = 0;
    step(3);
    chk("rstH_noack", 32'(wr_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pwm_cmp_update_ctrl.md
Name: pwm_cmp_update_ctrl

Overview:
Shadow-register update controller for the 16 PWM output-compare channels. It accepts per-channel compare settings (CMP_START, CMP_END, mode) from the I2C register file through a req/ack handshake and holds them in shadow registers. At the next counter period boundary it commits all pending channels to the active registers. Each channel's active registers drive its counter comparators and OC reference generator, so a channel's outputs never see a half-updated start/end pair mid-period.

Parameters:
NUM_CH, 16, number of PWM channels
CNT_W, 12, counter / compare value width
CH_W, 4, channel index width; must satisfy 2**CH_W >= NUM_CH

Ports:
clk_psc_i  in  1  prescaled PWM clock
rst_i  in  1  synchronous reset, active-high
wr_req_i  in  1  write request from register file; level, held until ack seen
wr_ch_i  in  CH_W  target channel
wr_start_i  in  CNT_W  new CMP_START
wr_end_i  in  CNT_W  new CMP_END
wr_mode_i  in  1  new mode
wr_ack_o  out  1  one-cycle write acknowledge
wr_err_o  out  1  qualifies wr_ack_o; write rejected
cnt_wrap_i  in  1  one-cycle pulse, counter reloads to 0 on this edge
upd_en_i  in  1  enables commit at wrap; 0 holds pending shadows
force_upd_i  in  1  one-cycle pulse, commits immediately regardless of upd_en_i
cmp_start_o  out  NUM_CH*CNT_W  active CMP_START; ch n at [n*CNT_W +: CNT_W]
cmp_end_o  out  NUM_CH*CNT_W  active CMP_END, same packing
mode_o  out  NUM_CH  active mode per channel
pend_o  out  NUM_CH  shadow-pending flag per channel
upd_done_o  out  1  one-cycle pulse after a commit of at least one channel
upd_cnt_o  out  8  commit-event counter; wraps 255->0

Behaviour:
- Reset (rst_i=1 at a clk edge) sets:
  - all active and shadow start/end to 0 and mode to 0
  - pend_o = 0
  - wr_ack_o = 0, wr_err_o = 0, upd_done_o = 0, upd_cnt_o = 0
  - FSM to IDLE
  Reset mid-handshake drops the write with no ack.
- Write FSM:
  - IDLE: on wr_req_i=1, go to ACK.
  - ACK: wr_ack_o=1 for exactly this cycle, then go to HOLD.
  - HOLD: stay until wr_req_i=0, then go to IDLE. This gives one ack per request; a new request needs wr_req_i low for at least one cycle.
  - Ack latency: wr_ack_o rises 1 cycle after wr_req_i is first sampled high. Write data is sampled in the IDLE->ACK cycle.
- Validation:
  - The write is rejected when wr_start_i > wr_end_i, or when wr_ch_i >= NUM_CH.
  - A rejected write gives wr_ack_o=1 and wr_err_o=1; shadow and pend_o are unchanged.
  - start == end is legal.
- Accepted write: shadow[ch] is loaded and pend_o[ch] is set in the ACK cycle. Writing an already-pending channel overwrites its shadow (last write wins).
- Commit:
  - Triggered by (cnt_wrap_i & upd_en_i) | force_upd_i.
  - Every channel with pend_o=1 copies shadow to active on that edge, and its pend_o clears. Active outputs change 1 cycle after the trigger is sampled.
  - upd_done_o pulses 1 cycle after the trigger and upd_cnt_o increments, but only if any pend_o bit was set. A trigger with nothing pending produces no pulse and no count.
- Simultaneous write and commit on the same edge: the commit uses the pre-write shadow. The written channel is then pending with the new value (pend_o stays 1) and commits at the next trigger.
- cnt_wrap_i and force_upd_i on the same edge give a single commit: one upd_done_o pulse and +1 on upd_cnt_o.
- upd_en_i=0: pending channels accumulate indefinitely. The first wrap after upd_en_i returns to 1 commits all of them together.
- Active outputs are registered only; there is no combinational path from any input to them.

Test Plan:
- Reset then idle: cmp_start_o, cmp_end_o, mode_o, pend_o, upd_cnt_o all 0; no wr_ack_o for 10 cycles.
- Write ch3 start=0x100 end=0x300 mode=1:
  - wr_ack_o is 1 at cycle+1 with wr_err_o=0, and pend_o=0x0008.
  - cmp_start_o for ch3 stays 0 until cnt_wrap_i; one cycle after the wrap ch3 reads 0x100/0x300/1.
  - pend_o=0, upd_done_o pulses, upd_cnt_o=1.
- Write ch5 with start=0x200 end=0x1FF: ack with wr_err_o=1; pend_o unchanged; the following wrap gives no upd_done_o.
- Write ch7 start=0x010 end=0x020 with ack on the same edge as cnt_wrap_i:
  - ch7 active stays 0 and pend_o[7]=1.
  - The next wrap commits ch7 = 0x010/0x020.
- upd_en_i=0, write ch0 and ch15, apply 3 wraps: no commit, pend_o=0x8001. Then force_upd_i: both commit in one cycle, upd_cnt_o +1.
- Hold wr_req_i high for 5 cycles: exactly one wr_ack_o. Assert rst_i while in HOLD: FSM returns to IDLE and all outputs are 0 the next cycle.
